lane_buffer_fifo: RTL and testbench
===================================

# lane_buffer_fifo

Parametrised successor to the two-word pipeline buffer register: a first-word-fall-through FIFO that holds up to DEPTH entries, each made of LANES words of WIDTH bits. It sits between a producing stage (or core) and a consuming stage in the multicore MIPS datapath. It decouples their rates with write/stall gating on the push side and a read strobe on the pop side. Occupancy, full and non-empty flags are exported so both sides can throttle.

## Interface
- WIDTH, 32, bits per lane word
- LANES, 2, words per entry (in_data/out_data = LANES*WIDTH bits, lane 0 in LSBs)
- DEPTH, 4, number of entries; power of two, ≥2
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high
- write  input  1  push request
- stall  input  1  pipeline stall; blocks push when high
- in_data  input  LANES*WIDTH  entry to push
- read  input  1  pop request
- out_data  output  LANES*WIDTH  head entry (FWFT); all zeros when empty
- valid  output  1  FIFO non-empty (head entry present)
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH+1)  current occupancy
- err_overflow  output  1  sticky: push attempted while full with no pop
- err_underflow  output  1  sticky: pop attempted while empty

## Operation
- push_ok = write & ~stall & (~full | pop_ok); pop_ok = read & valid.
- stall gates push only; pop proceeds regardless of stall.
- push_ok: in_data written at wr_ptr; wr_ptr increments modulo DEPTH.
- pop_ok: rd_ptr increments modulo DEPTH; head entry discarded.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full + push + pop in the same cycle: both accepted; the new entry is written into the slot just freed; count stays DEPTH.
- Empty + push + pop in the same cycle: pop is not accepted (valid=0); push is accepted; count becomes 1. There is no bypass path.
- out_data is driven combinationally from storage[rd_ptr] gated by valid; it is zero when empty.
- Write while full without a pop: data is dropped; pointers and count are unchanged.
- Read while empty: no effect on state.
- Storage array is not reset. Pointers, count, and error flags are reset.

## Timing
- Reset (sync): rd_ptr=0, wr_ptr=0, count=0. After reset: valid=0, full=0, out_data=0, err_overflow=0, err_underflow=0.
- Push latency: entry accepted at edge N is visible on out_data with valid=1 immediately after edge N, provided the FIFO was empty.
- Pop latency: after the pop edge, out_data shows the next entry, or zero if the FIFO is now empty.
- Reset asserted mid-operation overrides any push or pop in the same cycle. The FIFO is empty on the next cycle.
- The flags valid, full and count are registered-state derived and glitch-free relative to Clk.

## Configuration
- LANE_FIFO_ERR_EN defined: err_overflow sets on write & ~stall & full & ~pop_ok. err_underflow sets on read & ~valid. Both flags are sticky until Reset.
- LANE_FIFO_ERR_EN undefined: err_overflow and err_underflow ports remain, tied to constant 0, and no error logic is synthesised.

## Test plan
- Reset, then idle → count=0, valid=0, full=0, out_data=0, both err flags 0.
- DEPTH=4: push 0x11/0x22, 0x33/0x44, 0x55/0x66, 0x77/0x88 (lane1/lane0) → full=1, count=4. Pop four times → out_data sequence 0x11_..22, 0x33_..44, 0x55_..66, 0x77_..88; then valid=0, out_data=0.
- Full FIFO, write=1 read=1 with in_data=0xAA/0xBB → count stays 4, head advances, 0xAA/0xBB emerges 4 pops later. Wrap-around is covered by repeating this for 10 cycles.
- write=1 with stall=1 for 3 cycles → count unchanged. Deassert stall → one push per cycle resumes. In the same window, read=1 with stall=1 still pops.
- With LANE_FIFO_ERR_EN: write while full (no read) → err_overflow=1 and stays 1 after subsequent pops. Read while empty → err_underflow=1. Reset clears both. Without the macro, both stay 0.
- Reset asserted with count=3 during a simultaneous push+pop → next cycle count=0, valid=0, out_data=0.

Source files
------------

// File: rtl/lane_buffer_fifo.sv
//==============================================================================
// Module      : lane_buffer_fifo
// Description : First-word-fall-through FIFO of DEPTH entries, each entry
//               LANES words of WIDTH bits (lane 0 in the LSBs). Push is gated
//               by stall and full; pop is gated by valid. Exposes occupancy,
//               full and non-empty flags to both neighbouring stages.
//               Optional sticky overflow/underflow error flags are built only
//               when the macro LANE_FIFO_ERR_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lane_buffer_fifo #(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         write,
    input  logic                         stall,
    input  logic [LANES*WIDTH-1:0]       in_data,
    input  logic                         read,
    output logic [LANES*WIDTH-1:0]       out_data,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    localparam int c_DATA_W = LANES * WIDTH;
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);

    // Entry storage is deliberately left unreset; valid masks stale contents.
    logic [c_DATA_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_valid;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == c_CNT_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop_ok  = read & w_valid;
    assign w_push_ok = write & ~stall & (~w_full | w_pop_ok);

    assign valid    = w_valid;
    assign full     = w_full;
    assign count    = r_count;
    assign out_data = w_valid ? r_mem[r_rd_ptr] : '0;

    // Write accepted entries into storage at the write pointer.
    always_ff @(posedge Clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LANE_FIFO_ERR_EN
    logic r_err_ovf;
    logic r_err_udf;

    // Sticky error capture: dropped push while full, or pop request while empty.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (write & ~stall & w_full & ~w_pop_ok) begin
                r_err_ovf <= 1'b1;
            end
            if (read & ~w_valid) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_udf;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_buffer_fifo.sv
//==============================================================================
// Module      : tb_lane_buffer_fifo
// Description : Directed self-checking bench for lane_buffer_fifo
//               (DEPTH=4, LANES=2, WIDTH=32). Error-flag expectations follow
//               the LANE_FIFO_ERR_EN build option.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lane_buffer_fifo;

    localparam int c_WIDTH = 32;
    localparam int c_LANES = 2;
    localparam int c_DEPTH = 4;
    localparam int c_DW    = c_WIDTH * c_LANES;
    localparam int c_CW    = $clog2(c_DEPTH + 1);

`ifdef LANE_FIFO_ERR_EN
    localparam logic c_ERR_ON = 1'b1;
`else
    localparam logic c_ERR_ON = 1'b0;
`endif

    logic             Clk;
    logic             Reset;
    logic             write;
    logic             stall;
    logic [c_DW-1:0]  in_data;
    logic             read;
    logic [c_DW-1:0]  out_data;
    logic             valid;
    logic             full;
    logic [c_CW-1:0]  count;
    logic             err_overflow;
    logic             err_underflow;

    int n_tests;
    int n_fail;

    logic [c_DW-1:0] q_model [$];

    lane_buffer_fifo #(
        .WIDTH (c_WIDTH),
        .LANES (c_LANES),
        .DEPTH (c_DEPTH)
    ) u_dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .write         (write),
        .stall         (stall),
        .in_data       (in_data),
        .read          (read),
        .out_data      (out_data),
        .valid         (valid),
        .full          (full),
        .count         (count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_one(input logic [c_DW-1:0] d);
        write   = 1'b1;
        in_data = d;
        step();
        write   = 1'b0;
        q_model.push_back(d);
    endtask

    task automatic pop_check(input string tag);
        logic [c_DW-1:0] exp;
        exp = q_model.pop_front();
        check(tag, out_data, exp);
        read = 1'b1;
        step();
        read = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        write   = 1'b0;
        stall   = 1'b0;
        read    = 1'b0;
        in_data = '0;
        step();
        step();
        Reset = 1'b0;
        step();

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_full",  64'(full),  64'd0);
        check("rst_data",  out_data,   64'd0);
        check("rst_ovf",   64'(err_overflow),  64'd0);
        check("rst_udf",   64'(err_underflow), 64'd0);

        // Fill four entries; first entry falls through immediately
        push_one({32'h11, 32'h22});
        check("fwft_valid", 64'(valid), 64'd1);
        check("fwft_data",  out_data, 64'h00000011_00000022);
        push_one({32'h33, 32'h44});
        push_one({32'h55, 32'h66});
        push_one({32'h77, 32'h88});
        check("fill_full",  64'(full),  64'd1);
        check("fill_count", 64'(count), 64'd4);

        // Drain in order with hand-computed heads
        check("pop0", out_data, 64'h00000011_00000022);
        read = 1'b1; step();
        check("pop1", out_data, 64'h00000033_00000044);
        step();
        check("pop2", out_data, 64'h00000055_00000066);
        step();
        check("pop3", out_data, 64'h00000077_00000088);
        step();
        read = 1'b0;
        q_model.delete();
        check("drain_valid", 64'(valid), 64'd0);
        check("drain_data",  out_data,   64'd0);
        check("drain_count", 64'(count), 64'd0);

        // Refill, then simultaneous push+pop while full, wrapping pointers
        for (int k = 1; k <= 4; k++) begin
            push_one({32'h100 + 32'(k), 32'h200 + 32'(k)});
        end
        check("refill_full", 64'(full), 64'd1);
        for (int i = 0; i < 10; i++) begin
            logic [c_DW-1:0] exp;
            exp = q_model.pop_front();
            check($sformatf("pp_head%0d", i), out_data, exp);
            write   = 1'b1;
            read    = 1'b1;
            in_data = {32'hAA00 + 32'(i), 32'hBB00 + 32'(i)};
            q_model.push_back(in_data);
            step();
            check($sformatf("pp_count%0d", i), 64'(count), 64'd4);
        end
        write = 1'b0;
        read  = 1'b0;
        // Remaining entries are the last four pushed (i = 6..9)
        check("pp_tail0", out_data, 64'h0000AA06_0000BB06);
        for (int i = 0; i < 4; i++) begin
            pop_check($sformatf("pp_drain%0d", i));
        end
        check("pp_empty", 64'(valid), 64'd0);

        // Stall blocks pushes
        stall   = 1'b1;
        write   = 1'b1;
        in_data = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_cnt%0d", i), 64'(count), 64'd0);
        end
        stall = 1'b0;
        write = 1'b0;
        push_one(64'h0000_0001_0000_0002);
        check("unstall_c1", 64'(count), 64'd1);
        push_one(64'h0000_0003_0000_0004);
        check("unstall_c2", 64'(count), 64'd2);
        // Pop proceeds under stall while push is still blocked
        stall   = 1'b1;
        write   = 1'b1;
        read    = 1'b1;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        void'(q_model.pop_front());
        stall = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        check("stall_pop_cnt",  64'(count), 64'd1);
        check("stall_pop_head", out_data,   64'h0000_0003_0000_0004);
        pop_check("stall_drain");
        check("stall_empty", 64'(count), 64'd0);

        // Underflow: read while empty has no state effect
        read = 1'b1; step(); read = 1'b0;
        check("udf_count", 64'(count), 64'd0);
        check("udf_flag",  64'(err_underflow), 64'(c_ERR_ON));
        check("udf_ovf",   64'(err_overflow),  64'd0);

        // Overflow: write while full is dropped
        push_one(64'h0000_00A1_0000_00B1);
        push_one(64'h0000_00A2_0000_00B2);
        push_one(64'h0000_00A3_0000_00B3);
        push_one(64'h0000_00A4_0000_00B4);
        write   = 1'b1;
        in_data = 64'h0000_00EE_0000_00EE;
        step();
        write   = 1'b0;
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_flag",  64'(err_overflow), 64'(c_ERR_ON));
        for (int i = 0; i < 4; i++) begin
            pop_check($sformatf("ovf_drain%0d", i));
        end
        check("ovf_empty",  64'(valid), 64'd0);
        check("ovf_sticky", 64'(err_overflow), 64'(c_ERR_ON));

        // Reset with count=3 during simultaneous push+pop
        push_one(64'h1);
        push_one(64'h2);
        push_one(64'h3);
        check("pre_rst_cnt", 64'(count), 64'd3);
        Reset   = 1'b1;
        write   = 1'b1;
        read    = 1'b1;
        in_data = 64'h4;
        step();
        Reset = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        q_model.delete();
        check("mid_rst_cnt",   64'(count), 64'd0);
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_data",  out_data,   64'd0);
        check("mid_rst_ovf",   64'(err_overflow),  64'd0);
        check("mid_rst_udf",   64'(err_underflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
